// File: rtl/hazard_pkg.sv
// hazard_pkg: definitions shared by the hazard controller files.
//   FWD_RF / FWD_W / FWD_M : forward-select encodings for the E-stage operand muxes
//   mul_state_t            : state type of the multi-cycle execute tracker
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: the pipeline-facing signal bundle of the hazard controller.
//   master : datapath side; drives register addresses and stage controls,
//            receives stall/flush/forward selects and status
//   slave  : hazard controller side
// Parameters: REG_ADDR_W (register address width), CNT_W (perf counter width).
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic [REG_ADDR_W-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_ADDR_W-1:0] wreg_e, wreg_m, wreg_w;
  logic                  regwrite_e, regwrite_m, regwrite_w;
  logic                  memtoreg_e;
  logic                  mul_start_e;
  logic                  branch_taken_e;

  logic                  stall_f, stall_d, stall_e;
  logic                  flush_d, flush_e, flush_m;
  logic [1:0]            fwd_a_e, fwd_b_e;
  logic                  mul_busy, mul_done;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e,
           mul_start_e, branch_taken_e,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, mul_busy, mul_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e,
           mul_start_e, branch_taken_e,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, mul_busy, mul_done, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_mul_tracker.sv
// mul_tracker: tracks a multi-cycle op occupying the E stage for MUL_LAT cycles.
//   clk, reset   : clock, asynchronous active-low reset
//   mul_start_i  : E holds a multi-cycle op (held high while stalled)
//   mul_busy_o   : op is holding E (first MUL_LAT-1 cycles)
//   mul_done_o   : last E cycle of the op
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no op tracked; a start here is cycle 0 of a new op
//   BUSY  | op in flight, cnt_q = E cycles remaining including this one
//
// Busy/done are decoded from state and the live start input so the stall
// lands in the same cycle the op is first seen; a registered busy would be
// one cycle late.
module mul_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mul_start_i,
  output logic mul_busy_o,
  output logic mul_done_o
);

  localparam int                  CNT_BITS = $clog2(MUL_LAT);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MUL_LAT - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  mul_state_t          state_q;
  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_start_i) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          // a start seen here belongs to the op in flight
          if (cnt_q > CNT_ONE) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // gated by reset so both read 0 the instant reset drops
  assign mul_busy_o = reset & (((state_q == IDLE) & mul_start_i) |
                               ((state_q == BUSY) & (cnt_q > CNT_ONE)));
  assign mul_done_o = reset & (state_q == BUSY) & (cnt_q == CNT_ONE);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the 5-stage pipeline.
//   clk, reset : clock, asynchronous active-low reset
//   hz (slave) : register addresses / stage controls in; stall, flush,
//                forward selects, mul_busy/mul_done and perf counters out
// Optional feature: define HAZARD_PERF_EN to build the saturating stall and
// flush performance counters; otherwise stall_cnt/flush_cnt read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  logic mul_busy, mul_done, lu;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input logic                  rw_m,
                                         input logic [REG_ADDR_W-1:0] wr_m,
                                         input logic                  rw_w,
                                         input logic [REG_ADDR_W-1:0] wr_w);
    // M is younger than W, so its value wins when both match
    if (rw_m && (wr_m != '0) && (wr_m == src))      return FWD_M;
    else if (rw_w && (wr_w != '0) && (wr_w == src)) return FWD_W;
    else                                            return FWD_RF;
  endfunction

  mul_tracker #(.MUL_LAT(MUL_LAT)) u_mul_tracker (
    .clk         (clk),
    .reset       (reset),
    .mul_start_i (hz.mul_start_e),
    .mul_busy_o  (mul_busy),
    .mul_done_o  (mul_done)
  );

  assign lu = hz.memtoreg_e & hz.regwrite_e & (hz.wreg_e != '0) &
              ((hz.wreg_e == hz.rs_d) | (hz.wreg_e == hz.rt_d));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (reset) begin
      if (mul_busy) begin
        // E holds the multiply: freeze F/D/E and bubble into M
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (hz.branch_taken_e) begin
        // the load-using instruction in D is on the wrong path anyway
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign hz.stall_f  = stall_f;
  assign hz.stall_d  = stall_d;
  assign hz.stall_e  = stall_e;
  assign hz.flush_d  = flush_d;
  assign hz.flush_e  = flush_e;
  assign hz.flush_m  = flush_m;
  assign hz.mul_busy = mul_busy;
  assign hz.mul_done = mul_done;
  assign hz.fwd_a_e  = reset ? fwd_sel(hz.rs_e, hz.regwrite_m, hz.wreg_m,
                                       hz.regwrite_w, hz.wreg_w) : FWD_RF;
  assign hz.fwd_b_e  = reset ? fwd_sel(hz.rt_e, hz.regwrite_m, hz.wreg_m,
                                       hz.regwrite_w, hz.wreg_w) : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((flush_d | flush_e | flush_m) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_ADDR_W = 5;
  localparam int MUL_LAT    = 4;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs_d = '0; hz.rt_d = '0; hz.rs_e = '0; hz.rt_e = '0;
    hz.wreg_e = '0; hz.wreg_m = '0; hz.wreg_w = '0;
    hz.regwrite_e = 1'b0; hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0;
    hz.memtoreg_e = 1'b0; hz.mul_start_e = 1'b0; hz.branch_taken_e = 1'b0;
  endtask

  // advance to 1 time unit after the next rising edge; inputs change here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    // reset forces outputs low even with hazard-causing inputs present
    hz.regwrite_m = 1'b1; hz.wreg_m = 5'd5; hz.rs_e = 5'd5;
    hz.mul_start_e = 1'b1;
    #2;
    check("rst_fwd_a", 32'(hz.fwd_a_e), 32'(2'b00));
    check("rst_mul_busy", 32'(hz.mul_busy), 32'd0);
    check("rst_stall_f", 32'(hz.stall_f), 32'd0);
    check("rst_flush_m", 32'(hz.flush_m), 32'd0);
    check("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    // forwarding: M beats W
    cyc(); reset = 1'b1; clear_inputs();
    hz.regwrite_m = 1'b1; hz.wreg_m = 5'd5; hz.regwrite_w = 1'b1; hz.wreg_w = 5'd5;
    hz.rs_e = 5'd5; hz.rt_e = 5'd5;
    #1;
    check("fwd_a_m", 32'(hz.fwd_a_e), 32'(2'b10));
    check("fwd_b_m", 32'(hz.fwd_b_e), 32'(2'b10));
    check("fwd_no_stall", 32'(hz.stall_f), 32'd0);

    cyc(); hz.regwrite_m = 1'b0; hz.rt_e = 5'd7; #1;
    check("fwd_a_w", 32'(hz.fwd_a_e), 32'(2'b01));
    check("fwd_b_none", 32'(hz.fwd_b_e), 32'(2'b00));

    cyc(); hz.regwrite_m = 1'b1; hz.wreg_m = 5'd0; hz.wreg_w = 5'd0; hz.rs_e = 5'd0; #1;
    check("fwd_a_r0", 32'(hz.fwd_a_e), 32'(2'b00));

    cyc(); hz.wreg_m = 5'd3; hz.rt_e = 5'd3; hz.wreg_w = 5'd9; hz.rs_e = 5'd9; #1;
    check("fwd_a_w2", 32'(hz.fwd_a_e), 32'(2'b01));
    check("fwd_b_m2", 32'(hz.fwd_b_e), 32'(2'b10));

    // load-use on rt_d
    cyc(); clear_inputs();
    hz.memtoreg_e = 1'b1; hz.regwrite_e = 1'b1; hz.wreg_e = 5'd8; hz.rt_d = 5'd8; #1;
    check("lu_stall_f", 32'(hz.stall_f), 32'd1);
    check("lu_stall_d", 32'(hz.stall_d), 32'd1);
    check("lu_flush_e", 32'(hz.flush_e), 32'd1);
    check("lu_stall_e", 32'(hz.stall_e), 32'd0);
    check("lu_flush_d", 32'(hz.flush_d), 32'd0);

    cyc(); hz.memtoreg_e = 1'b0; #1;
    check("lu_gone_stall_f", 32'(hz.stall_f), 32'd0);
    check("lu_gone_flush_e", 32'(hz.flush_e), 32'd0);

    cyc(); hz.memtoreg_e = 1'b1; hz.wreg_e = 5'd0; hz.rt_d = 5'd0; #1;
    check("lu_r0_stall_f", 32'(hz.stall_f), 32'd0);

    cyc(); hz.wreg_e = 5'd4; hz.rt_d = 5'd1; hz.rs_d = 5'd4; #1;
    check("lu_rs_stall_d", 32'(hz.stall_d), 32'd1);

    // branch over load-use
    cyc(); hz.branch_taken_e = 1'b1; #1;
    check("br_flush_d", 32'(hz.flush_d), 32'd1);
    check("br_flush_e", 32'(hz.flush_e), 32'd1);
    check("br_stall_f", 32'(hz.stall_f), 32'd0);

    // multi-cycle op, cycles 0..3, then back-to-back op
    cyc(); clear_inputs(); hz.mul_start_e = 1'b1; #1;
    check("mul_c0_busy", 32'(hz.mul_busy), 32'd1);
    check("mul_c0_stall_e", 32'(hz.stall_e), 32'd1);
    check("mul_c0_flush_m", 32'(hz.flush_m), 32'd1);
    check("mul_c0_done", 32'(hz.mul_done), 32'd0);
    cyc(); hz.branch_taken_e = 1'b1; #1;
    check("mul_c1_stall_f", 32'(hz.stall_f), 32'd1);
    check("mul_c1_br_masked", 32'(hz.flush_d), 32'd0);
    cyc(); hz.branch_taken_e = 1'b0; #1;
    check("mul_c2_busy", 32'(hz.mul_busy), 32'd1);
    check("mul_c2_done", 32'(hz.mul_done), 32'd0);
    cyc(); #1;
    check("mul_c3_done", 32'(hz.mul_done), 32'd1);
    check("mul_c3_busy", 32'(hz.mul_busy), 32'd0);
    check("mul_c3_stall_f", 32'(hz.stall_f), 32'd0);
    cyc(); #1;
    check("mul2_c0_busy", 32'(hz.mul_busy), 32'd1);
    check("mul2_c0_done", 32'(hz.mul_done), 32'd0);
    cyc(); #1;
    check("mul2_c1_busy", 32'(hz.mul_busy), 32'd1);
    cyc(); #1;
    check("mul2_c2_busy", 32'(hz.mul_busy), 32'd1);

    // reset mid-op at cnt=2
    #1; reset = 1'b0; #1;
    check("rst_mid_busy", 32'(hz.mul_busy), 32'd0);
    check("rst_mid_stall_f", 32'(hz.stall_f), 32'd0);
    check("rst_mid_done", 32'(hz.mul_done), 32'd0);
    cyc(); reset = 1'b1; hz.mul_start_e = 1'b0; #1;
    check("post_rst_done", 32'(hz.mul_done), 32'd0);
    check("post_rst_busy", 32'(hz.mul_busy), 32'd0);
    cyc(); #1;
    check("post_rst_done2", 32'(hz.mul_done), 32'd0);
    cyc(); hz.mul_start_e = 1'b1; #1;
    check("post_rst_idle_start", 32'(hz.mul_busy), 32'd1);
    cyc(); #1; cyc(); #1; cyc(); #1;
    check("post_rst_done_c3", 32'(hz.mul_done), 32'd1);

    // 20 load-use stall cycles for the perf counters
    cyc(); clear_inputs();
    hz.memtoreg_e = 1'b1; hz.regwrite_e = 1'b1; hz.wreg_e = 5'd8; hz.rt_d = 5'd8;
    for (int i = 0; i < 19; i++) cyc();
    cyc(); clear_inputs(); #1;
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt", 32'(hz.stall_cnt), 32'd15);
    check("perf_flush_cnt", 32'(hz.flush_cnt), 32'd15);
`else
    check("perf_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("perf_flush_cnt", 32'(hz.flush_cnt), 32'd0);
`endif
    check("perf_end_stall_f", 32'(hz.stall_f), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline. It extends the basic hazard unit in three ways: it tracks a multi-cycle execute unit (multiplier) with a counter FSM, it handles taken-branch flushes resolved in E, and it adds optional performance counters. It sits beside the datapath and drives the stall, flush and forward selects for the F/D/E/M pipeline registers.

## Interface
- REG_ADDR_W, 5, register-address width
- MUL_LAT, 4, cycles a multi-cycle op occupies E (≥2)
- CNT_W, 16, performance-counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs_d, rt_d  in  REG_ADDR_W  decode-stage source registers
- rs_e, rt_e  in  REG_ADDR_W  execute-stage source registers
- wreg_e, wreg_m, wreg_w  in  REG_ADDR_W  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes the register file
- memtoreg_e  in  1  E holds a load
- mul_start_e  in  1  E holds a multi-cycle op; held high while it is stalled
- branch_taken_e  in  1  branch resolved taken in E
- stall_f, stall_d, stall_e  out  1  hold the PC / IF-ID / ID-EX registers
- flush_d, flush_e, flush_m  out  1  bubble into IF-ID / ID-EX / EX-MEM
- fwd_a_e, fwd_b_e  out  2  forward select: 00 regfile, 01 from W, 10 from M
- mul_busy  out  1  multi-cycle op is holding E
- mul_done  out  1  last E cycle of the multi-cycle op
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Forwarding (combinational), shown for A; B is identical with rt_e:
  - fwd_a_e=10 if regwrite_m & wreg_m≠0 & wreg_m==rs_e.
  - Else fwd_a_e=01 if regwrite_w & wreg_w≠0 & wreg_w==rs_e.
  - Else 00. M takes priority over W.
- Load-use: lu = memtoreg_e & regwrite_e & wreg_e≠0 & (wreg_e==rs_d | wreg_e==rt_d). Response: stall_f=stall_d=flush_e=1.
- Branch: branch_taken_e causes flush_d=flush_e=1 and no stall. It takes priority over lu.
- Multi-cycle FSM, states IDLE and BUSY, with counter cnt of width clog2(MUL_LAT):
  - IDLE & mul_start_e: mul_busy=1. Load cnt=MUL_LAT-1. Next state BUSY.
  - BUSY & cnt>1: mul_busy=1. cnt decrements.
  - BUSY & cnt==1: mul_busy=0, mul_done=1. Next state IDLE.
  - mul_start_e is ignored in BUSY.
- While mul_busy: stall_f=stall_d=stall_e=flush_m=1. Branch and lu are masked in this case, since E holds the multiply.
- Output priority: mul_busy > branch_taken_e > lu.
- While reset is low: FSM in IDLE, cnt=0, and all stall, flush, fwd, mul_busy and mul_done outputs are forced to 0.

## Timing
- Forward, load-use and branch outputs are combinational from same-cycle inputs, with zero latency.
- A multi-cycle op occupies E for exactly MUL_LAT cycles.
  - Stall is asserted for the first MUL_LAT-1 of them, starting in the cycle mul_start_e is first seen in IDLE.
  - mul_done is high in the final cycle.
  - The next instruction enters E in the following cycle.
- Back-to-back multi-cycle ops: the second mul_start_e arrives in the cycle after mul_done, while in IDLE, and starts a new sequence with no gap.
- Reset asserted mid-operation: state returns to IDLE and cnt to 0 immediately (asynchronous). The op is abandoned.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments each cycle stall_f=1.
  - flush_cnt increments each cycle flush_d|flush_e|flush_m=1.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- HAZARD_PERF_EN undefined: no counter registers are built, and stall_cnt and flush_cnt are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - the fwd select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - the FSM state typedef mul_state_t {IDLE, BUSY}.
- One sub-module, mul_tracker, holds the FSM and cnt and outputs mul_busy and mul_done. Forwarding, priority logic and counters stay in hazard_ctrl.

## Test plan
- Forwarding:
  - regwrite_m=1, wreg_m=5, regwrite_w=1, wreg_w=5, rs_e=5 → fwd_a_e=10.
  - Same with regwrite_m=0 → 01.
  - wreg_m=0 with rs_e=0 → 00.
- Load-use: memtoreg_e=1, regwrite_e=1, wreg_e=8, rt_d=8 → stall_f=stall_d=flush_e=1 for one cycle. With wreg_e=0 → no stall.
- Multi-cycle op, MUL_LAT=4, mul_start_e held 4 cycles → stalls high for cycles 0–2, mul_done in cycle 3, stall low in cycle 4. A back-to-back second op restarts at cycle 4.
- Branch and load-use together: branch_taken_e=1 with a concurrent lu condition → flush_d=flush_e=1, stall_f=0.
- Reset low during BUSY at cnt=2 → mul_busy=0 immediately. After release, IDLE with no spurious mul_done.
- HAZARD_PERF_EN with CNT_W=4: 20 stall cycles → stall_cnt=15 (saturated). Build without the macro → stall_cnt=0.
